controlador_botoes: RTL
=======================

Name: controlador_botoes

Overview:
- Multi-channel successor of the single-button controller: N independent debounced channels, each with press pulse, hold level, long-press pulse and release pulse.
- Sits between the raw FPGA button pins and the Tamagotchi game FSM, which consumes only single-cycle events.
- Adds input synchronisation, selectable polarity, bounce rejection on release, and long-press detection.

Parameters:
- N_BOTOES, 4, number of independent button channels (>=1).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a press or release (>=1).
- LONG_CYCLES, 200, cycles after b_press until b_long fires (> DEBOUNCE_CYCLES).
- ATIVO_BAIXO, 1, 1 = b_in low means pressed; 0 = b_in high means pressed.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- b_in  input  N_BOTOES  raw, asynchronous button pins.
- b_press  output  N_BOTOES  one-cycle pulse per accepted press.
- b_hold  output  N_BOTOES  level, high while a channel is in the accepted-pressed condition.
- b_long  output  N_BOTOES  one-cycle pulse, at most once per press, when the hold reaches LONG_CYCLES.
- b_release  output  N_BOTOES  one-cycle pulse per accepted release.

Behaviour:
- Reset:
  - All outputs are 0.
  - Every FSM is in SOLTO and every counter is 0.
  - Synchroniser flops take the inactive pin level.
  - Asserting rst mid-operation drops all outputs immediately. No b_release is generated.
- Synchroniser: each b_in bit passes through 2 flops, then is normalised to "ativo" (1 = pressed) according to ATIVO_BAIXO.
- Per-channel FSM, driven by the synchronised ativo bit:
  - SOLTO:
    - ativo -> DEB_PRESS, cnt = 1.
  - DEB_PRESS:
    - !ativo -> SOLTO, cnt cleared (bounce rejected, no output).
    - ativo and cnt == DEBOUNCE_CYCLES-1 -> PRESSIONADO; b_press = 1 for exactly that next cycle; long counter = 0.
    - Otherwise cnt increments.
  - PRESSIONADO:
    - b_hold = 1.
    - The long counter increments every cycle and saturates at LONG_CYCLES.
    - b_long pulses 1 cycle when the counter reaches LONG_CYCLES, exactly LONG_CYCLES cycles after the b_press cycle.
    - !ativo -> DEB_SOLTA, cnt = 1.
  - DEB_SOLTA:
    - b_hold stays 1 and the long counter keeps running.
    - ativo -> PRESSIONADO, with no new b_press and no repeat b_long.
    - !ativo and cnt == DEBOUNCE_CYCLES-1 -> SOLTO; b_release = 1 for exactly the next cycle; b_hold falls in the same cycle.
- DEBOUNCE_CYCLES = 1: DEB_PRESS and DEB_SOLTA last a single cycle.
- Latency: with edge 1 being the first edge that samples b_in active, b_press is high in the cycle after edge DEBOUNCE_CYCLES+2. Release has the same latency, measured from the first edge that samples inactive.
- Counters:
  - Widths are $clog2(max+1) and counters never wrap.
  - The debounce counter is cleared on every state change.
  - The long counter saturates, so a hold of any length yields exactly one b_long.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses.
- A button held through reset release is treated as a new press: b_press fires after the normal latency.
- b_press, b_long and b_release are mutually exclusive per channel in any cycle.

Decomposition:
- Shared package controlador_botoes_pkg holds:
  - state encoding localparams SOLTO, DEB_PRESS, PRESSIONADO, DEB_SOLTA (2 bits);
  - a counter-width helper function.
- Sub-module controlador_botao_canal contains one channel: synchroniser, polarity, FSM and counters. The top instantiates N_BOTOES copies in a generate loop.

Test Plan:
All scenarios use N_BOTOES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ATIVO_BAIXO=1.
- Reset: b_in=2'b11, rst pulsed mid-run -> all outputs 0 immediately; after release, 20 idle cycles with no pulse.
- Clean press: b_in[0]=0 held -> b_press[0] high exactly 1 cycle, after edge 6; b_hold[0] rises with it.
- Press bounce: b_in[0] low 2 cycles, high 1, low 2, then high -> no b_press; held low 4 cycles -> one b_press.
- Release glitch: while pressed, b_in[0] high 2 cycles then low -> b_hold stays 1, no b_release, no second b_press. Then high for 6 cycles -> b_release 1 cycle, b_hold 0.
- Long press: hold 30 cycles -> b_long[0] exactly once, 10 cycles after the b_press cycle; none on subsequent cycles.
- Two channels: both pressed on the same edge -> b_press=2'b11 in the same cycle. Channel 1 released early -> b_release[1] fires only; channel 0 unaffected.

Source files
------------

// File: rtl/controlador_botoes_pkg.sv
// -----------------------------------------------------------------------------
// controlador_botoes_pkg
// Definitions shared by the multi-channel button controller:
//   - estado_t : 2-bit encoding of the per-channel debounce FSM
//   - largura_cnt() : bit width needed to hold a counter value 0..max_val
// -----------------------------------------------------------------------------
package controlador_botoes_pkg;

    // Per-channel FSM states.
    //   SOLTO       : released, idle
    //   DEB_PRESS   : candidate press, counting stable active samples
    //   PRESSIONADO : accepted press (hold level high)
    //   DEB_SOLTA   : candidate release, hold still high while counting
    typedef enum logic [1:0] {
        SOLTO       = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSIONADO = 2'd2,
        DEB_SOLTA   = 2'd3
    } estado_t;

    // Width of a counter that must represent every value from 0 to max_val.
    // Never returns less than 1 so degenerate parameters still give a legal vector.
    function automatic int largura_cnt(input int max_val);
        if (max_val < 1) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

endpackage

// File: rtl/controlador_botao_canal.sv
// -----------------------------------------------------------------------------
// controlador_botao_canal
// One button channel: two-flop synchroniser, polarity normalisation, debounce
// FSM with press/release filtering and long-press detection.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   b_in       in   raw asynchronous button pin
//   b_press    out  one-cycle pulse when a press is accepted
//   b_hold     out  level, high while the press is accepted (PRESSIONADO/DEB_SOLTA)
//   b_long     out  one-cycle pulse LONG_CYCLES cycles after b_press, once per press
//   b_release  out  one-cycle pulse when a release is accepted
// -----------------------------------------------------------------------------
module controlador_botao_canal
    import controlador_botoes_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 200,
    parameter int ATIVO_BAIXO     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic b_in,
    output logic b_press,
    output logic b_hold,
    output logic b_long,
    output logic b_release
);

    localparam int CW = largura_cnt(DEBOUNCE_CYCLES);
    localparam int LW = largura_cnt(LONG_CYCLES);

    // The debounce counter starts at 1 on entry to a DEB state, so reaching
    // DEBOUNCE_CYCLES-1 means DEBOUNCE_CYCLES consecutive stable samples.
    localparam logic [CW-1:0] DEB_LIM  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_UM   = CW'(1);

    localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_ZERO = LW'(0);
    localparam logic [LW-1:0] LONG_UM   = LW'(1);

    // Pin level that means "not pressed"; synchroniser resets to it so that
    // reset release never looks like an edge.
    localparam logic PINO_INATIVO = (ATIVO_BAIXO != 0) ? 1'b1 : 1'b0;

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    estado_t         estado_q, estado_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   long_q, long_d;
    logic            press_q, press_d;
    logic            hold_q, hold_d;
    logic            long_pulse_q, long_pulse_d;
    logic            release_q, release_d;

    logic            ativo_s;
    logic [LW-1:0]   long_inc_s;
    logic            long_chega_s;

    // Synchroniser next-state and polarity normalisation
    always_comb begin
        sync1_d = b_in;
        sync2_d = sync1_q;
        if (ATIVO_BAIXO != 0) begin
            ativo_s = ~sync2_q;
        end else begin
            ativo_s = sync2_q;
        end
    end

    // Saturating long-press counter and its single "reaches LONG_CYCLES" event
    always_comb begin
        if (long_q < LONG_MAX) begin
            long_inc_s = long_q + LONG_UM;
        end else begin
            long_inc_s = long_q;
        end
        // Saturation guarantees this is true on exactly one cycle per press.
        long_chega_s = (long_q == (LONG_MAX - LONG_UM));
    end

    // Debounce FSM next-state, counters and output pulses
    always_comb begin
        estado_d     = estado_q;
        cnt_d        = cnt_q;
        long_d       = long_q;
        press_d      = 1'b0;
        long_pulse_d = 1'b0;
        release_d    = 1'b0;

        case (estado_q)
            SOLTO: begin
                long_d = LONG_ZERO;
                if (ativo_s) begin
                    estado_d = DEB_PRESS;
                    cnt_d    = CNT_UM;
                end else begin
                    cnt_d    = CNT_ZERO;
                end
            end

            DEB_PRESS: begin
                if (!ativo_s) begin
                    // Bounce: drop back silently.
                    estado_d = SOLTO;
                    cnt_d    = CNT_ZERO;
                end else if (cnt_q >= DEB_LIM) begin
                    estado_d = PRESSIONADO;
                    cnt_d    = CNT_ZERO;
                    long_d   = LONG_ZERO;
                    press_d  = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CNT_UM;
                end
            end

            PRESSIONADO: begin
                long_d       = long_inc_s;
                long_pulse_d = long_chega_s;
                if (!ativo_s) begin
                    estado_d = DEB_SOLTA;
                    cnt_d    = CNT_UM;
                end else begin
                    cnt_d    = CNT_ZERO;
                end
            end

            DEB_SOLTA: begin
                // Hold is still accepted here, so the long counter keeps going.
                long_d       = long_inc_s;
                long_pulse_d = long_chega_s;
                if (ativo_s) begin
                    // Release glitch: resume the press without new events.
                    estado_d = PRESSIONADO;
                    cnt_d    = CNT_ZERO;
                end else if (cnt_q >= DEB_LIM) begin
                    // Release wins over a coincident long event so the pulses
                    // stay mutually exclusive and nothing fires after release.
                    estado_d     = SOLTO;
                    cnt_d        = CNT_ZERO;
                    long_d       = LONG_ZERO;
                    long_pulse_d = 1'b0;
                    release_d    = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CNT_UM;
                end
            end

            default: begin
                estado_d = SOLTO;
                cnt_d    = CNT_ZERO;
                long_d   = LONG_ZERO;
            end
        endcase

        // Hold follows the next state so it rises with b_press and falls with b_release.
        hold_d = (estado_d == PRESSIONADO) || (estado_d == DEB_SOLTA);
    end

    // Synchroniser, FSM state, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= PINO_INATIVO;
            sync2_q      <= PINO_INATIVO;
            estado_q     <= SOLTO;
            cnt_q        <= CNT_ZERO;
            long_q       <= LONG_ZERO;
            press_q      <= 1'b0;
            hold_q       <= 1'b0;
            long_pulse_q <= 1'b0;
            release_q    <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            estado_q     <= estado_d;
            cnt_q        <= cnt_d;
            long_q       <= long_d;
            press_q      <= press_d;
            hold_q       <= hold_d;
            long_pulse_q <= long_pulse_d;
            release_q    <= release_d;
        end
    end

    assign b_press   = press_q;
    assign b_hold    = hold_q;
    assign b_long    = long_pulse_q;
    assign b_release = release_q;

endmodule

// File: rtl/controlador_botoes.sv
// -----------------------------------------------------------------------------
// controlador_botoes
// N_BOTOES independent debounced button channels feeding the game FSM with
// single-cycle events.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   b_in       in   [N_BOTOES] raw asynchronous button pins
//   b_press    out  [N_BOTOES] one-cycle pulse per accepted press
//   b_hold     out  [N_BOTOES] level while a channel is accepted-pressed
//   b_long     out  [N_BOTOES] one-cycle pulse LONG_CYCLES after b_press
//   b_release  out  [N_BOTOES] one-cycle pulse per accepted release
// -----------------------------------------------------------------------------
module controlador_botoes
    import controlador_botoes_pkg::*;
#(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 200,
    parameter int ATIVO_BAIXO     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_BOTOES-1:0] b_in,
    output logic [N_BOTOES-1:0] b_press,
    output logic [N_BOTOES-1:0] b_hold,
    output logic [N_BOTOES-1:0] b_long,
    output logic [N_BOTOES-1:0] b_release
);

    // Channels share nothing but clock and reset.
    for (genvar i = 0; i < N_BOTOES; i++) begin : g_canal
        controlador_botao_canal #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ATIVO_BAIXO     (ATIVO_BAIXO)
        ) u_canal (
            .clk       (clk),
            .rst       (rst),
            .b_in      (b_in[i]),
            .b_press   (b_press[i]),
            .b_hold    (b_hold[i]),
            .b_long    (b_long[i]),
            .b_release (b_release[i])
        );
    end

endmodule
